// File: rtl/fpu_round_sched.sv
// Result scheduler for the shared FPU round stage: arbitrates FMA / FDIV / FCVT results,
// registers the winner with its decoded rounding mode, and requests FMA bubbles on starvation.
module fpu_round_sched #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned RDW          = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           fma_valid,
    input  logic [RDW-1:0] fma_rd,
    input  logic [2:0]     fma_frm,
    input  logic [2:0]     fcsr_frm,
    input  logic           div_req,
    input  logic [51:0]    div_res,
    input  logic [RDW-1:0] div_rd,
    output logic           div_ack,
    input  logic           cvt_req,
    input  logic [51:0]    cvt_res,
    input  logic [RDW-1:0] cvt_rd,
    output logic           cvt_ack,
    input  logic           flush,
    output logic           issue_stall,
    output logic           rnd_valid,
    output logic           rnd_earlyressel,
    output logic [51:0]    rnd_earlyres,
    output logic [RDW-1:0] rnd_rd,
    output logic [1:0]     rnd_src,
    output logic           rz,
    output logic           rn,
    output logic           rp,
    output logic           rm,
    output logic           rnd_badfrm
);

    localparam logic [1:0] SrcFma = 2'b00;
    localparam logic [1:0] SrcDiv = 2'b01;
    localparam logic [1:0] SrcCvt = 2'b10;
    localparam logic [7:0] Limit  = 8'(STARVE_LIMIT);

    typedef enum logic {StRun, StStarved} state_t;

    state_t     state_q, state_d;
    logic       rr_q, rr_d;         // 0: DIV next on contention, 1: CVT
    logic       ssrc_q, ssrc_d;     // starving source, same encoding as rr
    logic [7:0] div_cnt_q, div_cnt_d;
    logic [7:0] cvt_cnt_q, cvt_cnt_d;

    logic       early_ok;
    logic       pick_cvt;
    logic       grant;
    logic [2:0] fma_eff_frm;
    logic [4:0] fma_dec;
    logic [4:0] early_dec;

    // Returns {rz, rn, rp, rm, badfrm}.
    function automatic logic [4:0] decode_frm(input logic [2:0] frm);
        logic [4:0] d;
        case (frm)
            3'b000:  d = 5'b01000;
            3'b001:  d = 5'b10000;
            3'b010:  d = 5'b00010;
            3'b011:  d = 5'b00100;
            3'b100:  d = 5'b01000;
            default: d = 5'b01001;
        endcase
        return d;
    endfunction

    // Acks drop combinationally while reset is held so a pending producer never sees a false ack.
    assign early_ok = !fma_valid && !flush && !reset;
    assign pick_cvt = (state_q == StStarved) ? ssrc_q : rr_q;
    assign div_ack  = early_ok && div_req && !(cvt_req && pick_cvt);
    assign cvt_ack  = early_ok && cvt_req && !(div_req && !pick_cvt);
    assign grant    = (fma_valid && !flush) || div_ack || cvt_ack;

    assign fma_eff_frm = (fma_frm == 3'b111) ? fcsr_frm : fma_frm;
    assign fma_dec     = decode_frm(fma_eff_frm);
    assign early_dec   = decode_frm(fcsr_frm) & 5'b11110;

    always_comb begin
        div_cnt_d = div_cnt_q;
        cvt_cnt_d = cvt_cnt_q;
        if (flush || !div_req || div_ack) begin
            div_cnt_d = '0;
        end else if (div_cnt_q != Limit) begin
            div_cnt_d = div_cnt_q + 8'd1;
        end
        if (flush || !cvt_req || cvt_ack) begin
            cvt_cnt_d = '0;
        end else if (cvt_cnt_q != Limit) begin
            cvt_cnt_d = cvt_cnt_q + 8'd1;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (div_ack) begin
            rr_d = 1'b1;
        end else if (cvt_ack) begin
            rr_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        ssrc_d  = ssrc_q;
        unique case (state_q)
            StRun: begin
                if (!flush && div_cnt_q == Limit) begin
                    state_d = StStarved;
                    ssrc_d  = 1'b0;
                end else if (!flush && cvt_cnt_q == Limit) begin
                    state_d = StStarved;
                    ssrc_d  = 1'b1;
                end
            end
            StStarved: begin
                if (flush) begin
                    state_d = StRun;
                end else if (ssrc_q ? (cvt_ack || !cvt_req) : (div_ack || !div_req)) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StRun;
            rr_q        <= 1'b0;
            ssrc_q      <= 1'b0;
            div_cnt_q   <= '0;
            cvt_cnt_q   <= '0;
            issue_stall <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            ssrc_q      <= ssrc_d;
            div_cnt_q   <= div_cnt_d;
            cvt_cnt_q   <= cvt_cnt_d;
            issue_stall <= (state_d == StStarved);
        end
    end

    // Data fields hold across idle cycles; only valid and earlyressel are forced low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rnd_valid       <= 1'b0;
            rnd_earlyressel <= 1'b0;
            rnd_earlyres    <= '0;
            rnd_rd          <= '0;
            rnd_src         <= SrcFma;
            rz              <= 1'b0;
            rn              <= 1'b1;
            rp              <= 1'b0;
            rm              <= 1'b0;
            rnd_badfrm      <= 1'b0;
        end else begin
            rnd_valid       <= grant;
            rnd_earlyressel <= div_ack || cvt_ack;
            if (grant) begin
                if (fma_valid) begin
                    rnd_src                     <= SrcFma;
                    rnd_rd                      <= fma_rd;
                    rnd_earlyres                <= '0;
                    {rz, rn, rp, rm, rnd_badfrm} <= fma_dec;
                end else if (div_ack) begin
                    rnd_src                     <= SrcDiv;
                    rnd_rd                      <= div_rd;
                    rnd_earlyres                <= div_res;
                    {rz, rn, rp, rm, rnd_badfrm} <= early_dec;
                end else begin
                    rnd_src                     <= SrcCvt;
                    rnd_rd                      <= cvt_rd;
                    rnd_earlyres                <= cvt_res;
                    {rz, rn, rp, rm, rnd_badfrm} <= early_dec;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_round_sched.sv
// Self-checking bench for fpu_round_sched: decode table, directed corner sequences,
// and randomized traffic against a cycle-level behavioural model.
module tb_fpu_round_sched;

    localparam int LIMIT = 8;
    localparam int RDW   = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic           fma_valid;
    logic [RDW-1:0] fma_rd;
    logic [2:0]     fma_frm;
    logic [2:0]     fcsr_frm;
    logic           div_req;
    logic [51:0]    div_res;
    logic [RDW-1:0] div_rd;
    logic           div_ack;
    logic           cvt_req;
    logic [51:0]    cvt_res;
    logic [RDW-1:0] cvt_rd;
    logic           cvt_ack;
    logic           flush;
    logic           issue_stall;
    logic           rnd_valid;
    logic           rnd_earlyressel;
    logic [51:0]    rnd_earlyres;
    logic [RDW-1:0] rnd_rd;
    logic [1:0]     rnd_src;
    logic           rz, rn, rp, rm;
    logic           rnd_badfrm;

    fpu_round_sched #(.STARVE_LIMIT(LIMIT), .RDW(RDW)) dut (
        .clk(clk), .reset(reset),
        .fma_valid(fma_valid), .fma_rd(fma_rd), .fma_frm(fma_frm), .fcsr_frm(fcsr_frm),
        .div_req(div_req), .div_res(div_res), .div_rd(div_rd), .div_ack(div_ack),
        .cvt_req(cvt_req), .cvt_res(cvt_res), .cvt_rd(cvt_rd), .cvt_ack(cvt_ack),
        .flush(flush), .issue_stall(issue_stall),
        .rnd_valid(rnd_valid), .rnd_earlyressel(rnd_earlyressel),
        .rnd_earlyres(rnd_earlyres), .rnd_rd(rnd_rd), .rnd_src(rnd_src),
        .rz(rz), .rn(rn), .rp(rp), .rm(rm), .rnd_badfrm(rnd_badfrm)
    );

    always #5 clk = ~clk;

    // Mode vectors as {rz, rn, rp, rm}.
    localparam logic [3:0] M_RZ = 4'b1000;
    localparam logic [3:0] M_RN = 4'b0100;
    localparam logic [3:0] M_RP = 4'b0010;
    localparam logic [3:0] M_RM = 4'b0001;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [2:0] frm;
        logic [2:0] fcsr;
        logic [3:0] mode;
        logic       bad;
    } vec_t;

    vec_t vecs[13];

    // Behavioural model state (0 = DIV, 1 = CVT for early sources).
    int          m_rr;
    int          m_cnt[2];
    bit          m_starved;
    int          m_ssrc;
    bit          m_stall;
    bit          m_ack[2];
    bit          m_valid;
    bit          m_sel;
    logic [51:0] m_res;
    logic [RDW-1:0] m_rd;
    logic [1:0]  m_src;
    logic [3:0]  m_mode;
    bit          m_bad;

    function automatic logic [3:0] mode_of(input logic [2:0] f);
        case (f)
            3'd1:    return M_RZ;
            3'd2:    return M_RM;
            3'd3:    return M_RP;
            default: return M_RN;
        endcase
    endfunction

    task automatic model_reset();
        m_rr = 0; m_cnt[0] = 0; m_cnt[1] = 0; m_starved = 0; m_ssrc = 0; m_stall = 0;
        m_ack[0] = 0; m_ack[1] = 0;
        m_valid = 0; m_sel = 0; m_res = '0; m_rd = '0; m_src = 2'b00; m_mode = M_RN; m_bad = 0;
    endtask

    task automatic model_ack();
        m_ack[0] = 0;
        m_ack[1] = 0;
        if (!fma_valid && !flush) begin
            if (div_req && cvt_req) m_ack[m_starved ? m_ssrc : m_rr] = 1;
            else if (div_req) m_ack[0] = 1;
            else if (cvt_req) m_ack[1] = 1;
        end
    endtask

    task automatic model_clock();
        bit req[2];
        bit ns;
        logic [2:0] eff;
        req[0] = div_req;
        req[1] = cvt_req;
        if (!flush && (fma_valid || m_ack[0] || m_ack[1])) begin
            m_valid = 1;
            if (fma_valid) begin
                eff = (fma_frm == 3'd7) ? fcsr_frm : fma_frm;
                m_sel = 0; m_src = 2'd0; m_rd = fma_rd; m_res = '0;
                m_mode = mode_of(eff); m_bad = (eff >= 3'd5);
            end else begin
                m_sel = 1; m_mode = mode_of(fcsr_frm); m_bad = 0;
                if (m_ack[0]) begin m_src = 2'd1; m_rd = div_rd; m_res = div_res; end
                else          begin m_src = 2'd2; m_rd = cvt_rd; m_res = cvt_res; end
            end
        end else begin
            m_valid = 0;
            m_sel = 0;
        end
        if (flush) ns = 0;
        else if (!m_starved) begin
            ns = 0;
            if (m_cnt[0] == LIMIT) begin ns = 1; m_ssrc = 0; end
            else if (m_cnt[1] == LIMIT) begin ns = 1; m_ssrc = 1; end
        end else ns = !(m_ack[m_ssrc] || !req[m_ssrc]);
        m_starved = ns;
        m_stall = ns;
        for (int s = 0; s < 2; s++)
            m_cnt[s] = (req[s] && !m_ack[s] && !flush) ? ((m_cnt[s] < LIMIT) ? m_cnt[s] + 1 : LIMIT)
                                                       : 0;
        if (m_ack[0]) m_rr = 1;
        else if (m_ack[1]) m_rr = 0;
    endtask

    task automatic idle_inputs();
        fma_valid = 0; fma_rd = '0; fma_frm = 3'd0; fcsr_frm = 3'd0;
        div_req = 0; div_res = '0; div_rd = '0;
        cvt_req = 0; cvt_res = '0; cvt_rd = '0; flush = 0;
    endtask

    initial begin
        vecs[0]  = '{3'b000, 3'b000, M_RN, 1'b0};
        vecs[1]  = '{3'b001, 3'b000, M_RZ, 1'b0};
        vecs[2]  = '{3'b010, 3'b000, M_RM, 1'b0};
        vecs[3]  = '{3'b011, 3'b001, M_RP, 1'b0};
        vecs[4]  = '{3'b100, 3'b000, M_RN, 1'b0};
        vecs[5]  = '{3'b101, 3'b000, M_RN, 1'b1};
        vecs[6]  = '{3'b110, 3'b011, M_RN, 1'b1};
        vecs[7]  = '{3'b111, 3'b010, M_RM, 1'b0};
        vecs[8]  = '{3'b111, 3'b011, M_RP, 1'b0};
        vecs[9]  = '{3'b111, 3'b001, M_RZ, 1'b0};
        vecs[10] = '{3'b111, 3'b101, M_RN, 1'b1};
        vecs[11] = '{3'b111, 3'b111, M_RN, 1'b1};
        vecs[12] = '{3'b111, 3'b100, M_RN, 1'b0};

        idle_inputs();
        reset = 1;
        #23;
        chk("reset_rn", rn, 1);
        chk("reset_mode", {rz, rn, rp, rm}, M_RN);
        chk("reset_valid", rnd_valid, 0);
        chk("reset_stall", issue_stall, 0);
        chk("reset_src", rnd_src, 0);
        @(negedge clk);
        reset = 0;

        // FMA decode table.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            fma_valid = 1;
            fma_frm   = vecs[i].frm;
            fcsr_frm  = vecs[i].fcsr;
            fma_rd    = 5'(7 + i);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_valid", i), rnd_valid, 1);
            chk($sformatf("tbl%0d_src", i), rnd_src, 0);
            chk($sformatf("tbl%0d_rd", i), rnd_rd, 64'(7 + i));
            chk($sformatf("tbl%0d_sel", i), rnd_earlyressel, 0);
            chk($sformatf("tbl%0d_mode", i), {rz, rn, rp, rm}, vecs[i].mode);
            chk($sformatf("tbl%0d_bad", i), rnd_badfrm, vecs[i].bad);
        end

        // Both early sources contending: strict alternation starting at DIV.
        @(negedge clk);
        idle_inputs();
        fcsr_frm = 3'b011;
        div_req = 1; cvt_req = 1; div_rd = 5'd3; cvt_rd = 5'd9;
        for (int i = 0; i < 4; i++) begin
            div_res = 52'h1_0000_0000_0000 + 52'(i);
            cvt_res = 52'h2_0000_0000_0000 + 52'(i);
            #1;
            chk($sformatf("alt%0d_div_ack", i), div_ack, (i % 2 == 0));
            chk($sformatf("alt%0d_cvt_ack", i), cvt_ack, (i % 2 == 1));
            @(posedge clk); #1;
            chk($sformatf("alt%0d_res", i), rnd_earlyres,
                (i % 2 == 0) ? 64'h1_0000_0000_0000 + 64'(i) : 64'h2_0000_0000_0000 + 64'(i));
            chk($sformatf("alt%0d_src", i), rnd_src, (i % 2 == 0) ? 1 : 2);
            chk($sformatf("alt%0d_sel", i), rnd_earlyressel, 1);
            chk($sformatf("alt%0d_mode", i), {rz, rn, rp, rm}, M_RP);
            @(negedge clk);
        end
        idle_inputs();

        // DIV starved by continuous FMA traffic.
        @(negedge clk);
        div_req = 1; div_res = 52'hABCDE; div_rd = 5'd21; fma_valid = 1;
        for (int k = 1; k <= 11; k++) begin
            #1 chk($sformatf("starve%0d_ack", k), div_ack, 0);
            @(posedge clk); #1;
            chk($sformatf("starve%0d_stall", k), issue_stall, (k >= 9));
            @(negedge clk);
        end
        fma_valid = 0;
        #1 chk("starve_release_ack", div_ack, 1);
        chk("starve_release_stall_held", issue_stall, 1);
        @(posedge clk); #1;
        chk("starve_release_stall", issue_stall, 0);
        chk("starve_release_src", rnd_src, 1);
        chk("starve_release_res", rnd_earlyres, 64'hABCDE);
        @(negedge clk);
        div_req = 0;

        // Flush clears the counter and suppresses the ack.
        @(negedge clk);
        div_req = 1; div_res = 52'h55; div_rd = 5'd4; fma_valid = 1;
        repeat (5) @(negedge clk);
        flush = 1;
        #1 chk("flush_ack", div_ack, 0);
        @(posedge clk); #1;
        chk("flush_valid", rnd_valid, 0);
        @(negedge clk);
        flush = 0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            chk($sformatf("postflush%0d_stall", k), issue_stall, 0);
            @(negedge clk);
        end
        fma_valid = 0;
        #1 chk("postflush_ack", div_ack, 1);
        @(posedge clk); #1;
        chk("postflush_valid", rnd_valid, 1);
        chk("postflush_src", rnd_src, 1);
        chk("postflush_stall", issue_stall, 0);

        // Reset applied while an ack is being given.
        @(negedge clk);
        div_res = 52'h77;
        #1 chk("rstmid_pre_ack", div_ack, 1);
        reset = 1;
        #1;
        chk("rstmid_ack", div_ack, 0);
        chk("rstmid_valid", rnd_valid, 0);
        chk("rstmid_rn", rn, 1);
        chk("rstmid_stall", issue_stall, 0);
        chk("rstmid_res", rnd_earlyres, 0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        reset = 0;
        model_reset();

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            int pct;
            @(negedge clk);
            pct = ((c / 150) % 2 == 1) ? 92 : 35;
            if (!div_req || m_ack[0]) begin
                div_req = ($urandom_range(0, 1) == 1);
                div_res = 52'({$urandom(), $urandom()});
                div_rd  = 5'($urandom());
            end
            if (!cvt_req || m_ack[1]) begin
                cvt_req = ($urandom_range(0, 1) == 1);
                cvt_res = 52'({$urandom(), $urandom()});
                cvt_rd  = 5'($urandom());
            end
            fma_valid = ($urandom_range(0, 99) < pct);
            fma_rd    = 5'($urandom());
            fma_frm   = 3'($urandom());
            fcsr_frm  = 3'($urandom());
            flush     = ($urandom_range(0, 99) < 4);
            #1;
            model_ack();
            chk("rand_div_ack", div_ack, m_ack[0]);
            chk("rand_cvt_ack", cvt_ack, m_ack[1]);
            @(posedge clk);
            model_clock();
            #1;
            chk("rand_valid", rnd_valid, m_valid);
            chk("rand_sel", rnd_earlyressel, m_sel);
            chk("rand_res", rnd_earlyres, m_res);
            chk("rand_rd", rnd_rd, m_rd);
            chk("rand_src", rnd_src, m_src);
            chk("rand_mode", {rz, rn, rp, rm}, m_mode);
            chk("rand_bad", rnd_badfrm, m_bad);
            chk("rand_stall", issue_stall, m_stall);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_round_sched.md
Name: fpu_round_sched

Overview:
- Scheduler for the shared FPU rounding/result-select stage.
- Arbitrates each cycle between three sources:
  - the fixed-latency FMA normalized-result stream, which cannot be stalled;
  - the FDIV early result;
  - the FCVT early result.
- Registers the winner together with the decoded one-hot rounding mode, and with the earlyressel/earlyres controls the round stage consumes.
- Prevents early-result starvation by requesting issue bubbles from the FMA issue logic.

Parameters:
- STARVE_LIMIT, 8, consecutive ungranted cycles of an early requester before issue_stall is raised (range 1..255).
- RDW, 5, destination-register tag width.

Ports:
- clk in 1 — clock
- reset in 1 — asynchronous reset, active-high
- fma_valid in 1 — FMA normalized sum present at round-stage input this cycle
- fma_rd in RDW — FMA destination tag
- fma_frm in 3 — instruction rounding-mode field
- fcsr_frm in 3 — dynamic rounding mode from fcsr
- div_req in 1 — FDIV result pending; held stable until div_ack
- div_res in 52 — FDIV result fraction
- div_rd in RDW — FDIV destination tag
- div_ack out 1 — FDIV result accepted this cycle (combinational)
- cvt_req in 1 — FCVT result pending; held stable until cvt_ack
- cvt_res in 52 — FCVT result fraction
- cvt_rd in RDW — FCVT destination tag
- cvt_ack out 1 — FCVT result accepted this cycle (combinational)
- flush in 1 — pipeline flush
- issue_stall out 1 — registered; asks FMA issue to insert bubbles
- rnd_valid out 1 — round stage holds a valid selection
- rnd_earlyressel out 1 — round stage selects rnd_earlyres
- rnd_earlyres out 52 — early result to the round stage
- rnd_rd out RDW — destination tag
- rnd_src out 2 — 00 FMA, 01 DIV, 10 CVT
- rz out 1 — round-mode one-hot: round toward zero
- rn out 1 — round-mode one-hot: round to nearest
- rp out 1 — round-mode one-hot: round toward +inf
- rm out 1 — round-mode one-hot: round toward -inf
- rnd_badfrm out 1 — effective frm illegal

Behaviour:

Reset (async, high):
- All outputs are 0, except rn=1 (RNE default).
- FSM is in RUN; rr_ptr=DIV; both starve counters are 0.

Grant (combinational, cycle N):
- FMA wins whenever fma_valid=1; div_ack and cvt_ack are both 0.
- Otherwise, if exactly one early req is high, it is acked.
- If both early reqs are high, the one pointed to by rr_ptr is acked. rr_ptr then points to the other source (updates only on an early grant).
- Exactly one or zero acks per cycle. No ack in a flush cycle.

Output register (N+1 = grant cycle + 1; latency 1):
- rnd_valid = grant occurred and !flush.
- rnd_src is the winner.
- rnd_rd is the winner's tag.
- rnd_earlyressel = 1 for DIV/CVT.
- rnd_earlyres = winner's res for DIV/CVT, 0 for FMA.
- With no grant: rnd_valid=0, rnd_earlyressel=0; other data fields hold their value.

Rounding-mode decode:
- Effective frm = fcsr_frm if fma_frm=111, else fma_frm.
- Mapping:
  - 000 → rn
  - 001 → rz
  - 010 → rm
  - 011 → rp
  - 100 (RMM) → rn
  - 101/110 → rn with rnd_badfrm=1
  - 111 in fcsr_frm → rn with rnd_badfrm=1
- Decode is registered with the output stage.
- For early grants: rz/rn/rp/rm use fcsr_frm and rnd_badfrm=0.

Starvation counters (one per early source):
- Increment (saturating at STARVE_LIMIT) each cycle req=1 and ack=0.
- Clear on ack, on req=0, or on flush.

FSM:
- RUN:
  - issue_stall=0.
  - Go to STARVED when either counter == STARVE_LIMIT.
  - The starving source is latched in starve_src; on a tie, DIV is chosen.
- STARVED:
  - issue_stall=1 (registered, asserted the cycle after entry).
  - Return to RUN when the starving source is acked, drops req, or flush=1.
  - issue_stall=0 the following cycle.
  - While STARVED, when both early reqs are high and FMA is idle, starve_src overrides rr_ptr.

Flush:
- Same cycle: acks are suppressed.
- Next cycle: rnd_valid=0, counters are 0, FSM is in RUN.
- rr_ptr is unchanged.
- Producers keep their reqs.

Simultaneous events:
- fma_valid while issue_stall=1 is legal; FMA still wins.
- A req rising in the same cycle its counter was cleared starts counting at 1 the next cycle.

Reset mid-operation: every output returns to the reset value immediately (async); pending acks drop.

Test Plan:
1. Reset applied mid-grant (div_ack=1) → div_ack=0 and rnd_valid=0 immediately; rn=1; issue_stall=0.
2. fma_valid=1, fma_frm=011, fma_rd=7 → next cycle rnd_valid=1, rnd_src=00, rp=1, rnd_rd=7, rnd_earlyressel=0.
3. fma_frm=111, fcsr_frm=010 → rm=1. fcsr_frm=101 → rn=1, rnd_badfrm=1.
4. div_req and cvt_req held high, fma idle, 4 cycles → acks alternate DIV, CVT, DIV, CVT. rnd_earlyres tracks div_res/cvt_res one cycle later.
5. div_req high with fma_valid high continuously, STARVE_LIMIT=8 → counter reaches 8; issue_stall=1 the following cycle. When fma_valid drops, div_ack=1 and issue_stall=0 the cycle after.
6. Flush asserted with div_req=1 and fma_valid=1 → no ack that cycle; rnd_valid=0 next cycle; counter=0. div_ack=1 on the first non-flush cycle with FMA idle.
